spi_cmd_decoder: RTL and testbench
==================================

SPI_CMD_DECODER -- requirements
Module: spi_cmd_decoder

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, meaning the number of PWM channels (1..4).
REQ-002 SHALL have parameter ID_VALUE, default 8'hA5, meaning the read-only identification byte.
REQ-003 i_Clk  input  1  system clock; one clock domain, all logic on its rising edge.
REQ-004 i_Rst  input  1  reset; synchronous and active-high.
REQ-005 i_CS_n  input  1  frame select from the SPI slave, already synchronised to i_Clk, active-low.
REQ-006 i_RX_DV  input  1  one-cycle pulse; i_RX_Byte is valid.
REQ-007 i_RX_Byte  input  8  byte received on MOSI.
REQ-008 o_TX_DV  output  1  one-cycle pulse; o_TX_Byte is loaded for the next MISO byte.
REQ-009 o_TX_Byte  output  8  readback byte to the SPI slave.
REQ-010 o_Enable  output  NUM_CH  per-channel PWM enable.
REQ-011 o_Prescale  output  8  PWM clock prescale.
REQ-012 o_Duty  output  8*NUM_CH  packed duties; channel k occupies bits [8k+7:8k].
REQ-013 o_Update  output  1  one-cycle pulse when new settings are committed to the outputs.

Function
REQ-014 Frame format SHALL be: first byte after i_CS_n falls is the command, bit7 = 1 for write and 0 for read, bits[6:0] = start address; every following byte is data.
REQ-015 FSM states SHALL be IDLE, CMD, WR, RD.
REQ-016 Transitions SHALL be IDLE->CMD when i_CS_n = 0; CMD->WR or CMD->RD on i_RX_DV, selected by bit7; any state->IDLE when i_CS_n = 1.
REQ-017 i_RX_DV SHALL be ignored while i_CS_n = 1 or in IDLE.
REQ-018 Register map: 0x00 CTRL (enables, bits[NUM_CH-1:0]); 0x01 PRESCALE; 0x02+k DUTYk for k < NUM_CH; 0x7F ID (read-only).
REQ-019 Writes SHALL go to shadow registers only.
REQ-020 Writes to ID, unmapped addresses, or CTRL bits >= NUM_CH SHALL be discarded.
REQ-021 In WR, each i_RX_Byte SHALL be written to shadow[addr], then addr increments by 1.
REQ-022 In RD, the command byte and every later i_RX_DV SHALL produce o_TX_DV exactly 1 cycle later, with o_TX_Byte = shadow[addr].
REQ-023 In RD, addr SHALL increment after each o_TX_DV is issued.
REQ-024 In RD, ID reads return ID_VALUE and unmapped reads return 8'h00.
REQ-025 The 7-bit address SHALL wrap 0x7F -> 0x00 in both WR and RD.
REQ-026 Commit point: the cycle in which i_CS_n = 1 and its registered copy = 0 (frame end).
REQ-027 At the commit point, if at least one mapped write occurred in the frame, shadow SHALL be copied to o_Enable/o_Prescale/o_Duty on that clock edge, and o_Update SHALL be high in the following cycle only.
REQ-028 Frames that are read-only, hold only a command, or are aborted with no data byte SHALL not commit and SHALL not pulse o_Update.
REQ-029 If i_RX_DV and the i_CS_n rise arrive in the same cycle, the byte SHALL be dropped and the commit SHALL proceed with the earlier writes.
REQ-030 A new frame starting while o_Update is high SHALL be accepted normally.

Reset
REQ-031 With i_Rst = 1 at a clock edge: FSM = IDLE; addr, the write flag, all shadow registers and all outputs SHALL go to 0; the registered i_CS_n copy SHALL go to 1.
REQ-032 A reset mid-frame SHALL discard the frame; no commit and no o_Update SHALL follow, even when i_CS_n later rises.

Structure
REQ-033 A shared package spi_pwm_pkg SHALL hold the address constants (ADDR_CTRL, ADDR_PRESCALE, ADDR_DUTY0, ADDR_ID), the FSM state enum and the ID_VALUE default.
REQ-034 The block SHALL be one module with no sub-module; the shadow/active register pair is small enough to stay inline.

Verification
REQ-035 Write 0x80, 0x0F, 0x03, 0x10, 0x20, 0x30, 0x40, then CS_n rises -> o_Enable = 4'hF, o_Prescale = 3, o_Duty = 32'h40302010, one o_Update pulse.
REQ-036 Read 0x02 followed by 3 dummy bytes -> o_TX_Byte sequence 0x10, 0x20, 0x30, 0x40, each o_TX_DV exactly 1 cycle after its i_RX_DV; no o_Update.
REQ-037 Write 0xFF (address 0x7F), 0x55, 0x07 -> ID unchanged, 0x07 lands in CTRL via wrap; after CS_n rises, o_Enable = 4'h7 and read of 0x7F returns 0xA5.
REQ-038 Write 0x82, 0x99, then i_Rst pulse, then CS_n rises -> all outputs 0, no o_Update.
REQ-039 Write 0x83, 0x11 with a second i_RX_DV coinciding with the CS_n rise -> DUTY1 = 0x11 committed, DUTY2 = 0, single o_Update.

Source files
------------

// File: rtl/spi_pwm_pkg.sv
// Shared definitions for the SPI-controlled PWM register block:
// register addresses, decoder FSM states and the default ID byte.
package spi_pwm_pkg;

  localparam int unsigned ADDR_W = 7;
  localparam int unsigned DATA_W = 8;

  localparam logic [ADDR_W-1:0] ADDR_CTRL     = 7'h00;
  localparam logic [ADDR_W-1:0] ADDR_PRESCALE = 7'h01;
  localparam logic [ADDR_W-1:0] ADDR_DUTY0    = 7'h02;
  localparam logic [ADDR_W-1:0] ADDR_ID       = 7'h7F;

  localparam logic [DATA_W-1:0] ID_VALUE_DEFAULT = 8'hA5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_WR   = 2'd2,
    ST_RD   = 2'd3
  } state_t;

endpackage : spi_pwm_pkg

// File: rtl/spi_cmd_decoder.sv
// SPI command decoder: frames of [cmd, data...] write shadow registers or read
// them back; shadow settings are committed to the PWM outputs at frame end.
module spi_cmd_decoder
  import spi_pwm_pkg::*;
#(
  parameter int unsigned       NUM_CH   = 4,
  parameter logic [DATA_W-1:0] ID_VALUE = ID_VALUE_DEFAULT
) (
  input  logic                     i_Clk,
  input  logic                     i_Rst,
  input  logic                     i_CS_n,
  input  logic                     i_RX_DV,
  input  logic [DATA_W-1:0]        i_RX_Byte,
  output logic                     o_TX_DV,
  output logic [DATA_W-1:0]        o_TX_Byte,
  output logic [NUM_CH-1:0]        o_Enable,
  output logic [DATA_W-1:0]        o_Prescale,
  output logic [DATA_W*NUM_CH-1:0] o_Duty,
  output logic                     o_Update
);

  state_t              state;
  logic [ADDR_W-1:0]   addr;
  logic                wr_flag;
  logic                cs_q;

  logic [NUM_CH-1:0]   shadow_en;
  logic [DATA_W-1:0]   shadow_pre;
  logic [DATA_W-1:0]   shadow_duty [NUM_CH];

  logic [ADDR_W-1:0]   rd_addr_c;
  logic [DATA_W-1:0]   rd_data_c;
  logic                wr_ctrl_c;
  logic                wr_pre_c;
  logic [NUM_CH-1:0]   wr_duty_c;
  logic                wr_hit_c;

  // Read mux: in CMD the address comes straight from the command byte.
  always_comb begin
    rd_addr_c = (state == ST_CMD) ? i_RX_Byte[ADDR_W-1:0] : addr;
    rd_data_c = '0;
    if (rd_addr_c == ADDR_CTRL) begin
      rd_data_c = DATA_W'(shadow_en);
    end else if (rd_addr_c == ADDR_PRESCALE) begin
      rd_data_c = shadow_pre;
    end else if (rd_addr_c == ADDR_ID) begin
      rd_data_c = ID_VALUE;
    end
    for (int k = 0; k < NUM_CH; k++) begin
      if (rd_addr_c == ADDR_DUTY0 + ADDR_W'(k)) begin
        rd_data_c = shadow_duty[k];
      end
    end
  end

  // Write decode for the current address; ID and unmapped addresses never hit.
  always_comb begin
    wr_ctrl_c = (addr == ADDR_CTRL);
    wr_pre_c  = (addr == ADDR_PRESCALE);
    wr_duty_c = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      wr_duty_c[k] = (addr == ADDR_DUTY0 + ADDR_W'(k));
    end
    wr_hit_c = wr_ctrl_c | wr_pre_c | (|wr_duty_c);
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state      <= ST_IDLE;
      addr       <= '0;
      wr_flag    <= 1'b0;
      cs_q       <= 1'b1;
      shadow_en  <= '0;
      shadow_pre <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        shadow_duty[k] <= '0;
      end
      o_TX_DV    <= 1'b0;
      o_TX_Byte  <= '0;
      o_Enable   <= '0;
      o_Prescale <= '0;
      o_Duty     <= '0;
      o_Update   <= 1'b0;
    end else begin
      cs_q     <= i_CS_n;
      o_TX_DV  <= 1'b0;
      o_Update <= 1'b0;

      if (i_CS_n) begin
        // Any byte arriving with the CS rise is dropped; earlier writes still commit.
        state   <= ST_IDLE;
        wr_flag <= 1'b0;
        if (!cs_q && wr_flag) begin
          o_Enable   <= shadow_en;
          o_Prescale <= shadow_pre;
          for (int k = 0; k < NUM_CH; k++) begin
            o_Duty[DATA_W*k +: DATA_W] <= shadow_duty[k];
          end
          o_Update <= 1'b1;
        end
      end else begin
        unique case (state)
          ST_IDLE: begin
            state <= ST_CMD;
          end

          ST_CMD: begin
            if (i_RX_DV) begin
              if (i_RX_Byte[DATA_W-1]) begin
                state <= ST_WR;
                addr  <= i_RX_Byte[ADDR_W-1:0];
              end else begin
                state     <= ST_RD;
                addr      <= i_RX_Byte[ADDR_W-1:0] + ADDR_W'(1);
                o_TX_DV   <= 1'b1;
                o_TX_Byte <= rd_data_c;
              end
            end
          end

          ST_WR: begin
            if (i_RX_DV) begin
              if (wr_ctrl_c) begin
                shadow_en <= i_RX_Byte[NUM_CH-1:0];
              end
              if (wr_pre_c) begin
                shadow_pre <= i_RX_Byte;
              end
              for (int k = 0; k < NUM_CH; k++) begin
                if (wr_duty_c[k]) begin
                  shadow_duty[k] <= i_RX_Byte;
                end
              end
              if (wr_hit_c) begin
                wr_flag <= 1'b1;
              end
              addr <= addr + ADDR_W'(1);
            end
          end

          ST_RD: begin
            if (i_RX_DV) begin
              o_TX_DV   <= 1'b1;
              o_TX_Byte <= rd_data_c;
              addr      <= addr + ADDR_W'(1);
            end
          end

          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule : spi_cmd_decoder

// File: tb/tb_spi_cmd_decoder.sv
// Directed bench for spi_cmd_decoder: write/read frames, address wrap,
// reset mid-frame, coincident CS rise and back-to-back frames.
module tb_spi_cmd_decoder;

  localparam int unsigned NUM_CH = 4;

  logic        i_Clk;
  logic        i_Rst;
  logic        i_CS_n;
  logic        i_RX_DV;
  logic [7:0]  i_RX_Byte;
  logic        o_TX_DV;
  logic [7:0]  o_TX_Byte;
  logic [NUM_CH-1:0] o_Enable;
  logic [7:0]  o_Prescale;
  logic [8*NUM_CH-1:0] o_Duty;
  logic        o_Update;

  int checks;
  int errors;
  int upd_cnt;
  int tx_cnt;
  int upd_base;
  int tx_base;

  spi_cmd_decoder #(
    .NUM_CH  (NUM_CH),
    .ID_VALUE(8'hA5)
  ) dut (
    .i_Clk     (i_Clk),
    .i_Rst     (i_Rst),
    .i_CS_n    (i_CS_n),
    .i_RX_DV   (i_RX_DV),
    .i_RX_Byte (i_RX_Byte),
    .o_TX_DV   (o_TX_DV),
    .o_TX_Byte (o_TX_Byte),
    .o_Enable  (o_Enable),
    .o_Prescale(o_Prescale),
    .o_Duty    (o_Duty),
    .o_Update  (o_Update)
  );

  initial i_Clk = 1'b0;
  always #5 i_Clk = ~i_Clk;

  // Pulse counters sampled away from the active edge.
  always @(negedge i_Clk) begin
    if (o_Update) upd_cnt++;
    if (o_TX_DV)  tx_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge i_Clk);
  endtask

  task automatic start_frame();
    @(negedge i_Clk);
    i_CS_n = 1'b0;
    idle(2);
  endtask

  // Leaves the bench at the negedge right after the commit edge.
  task automatic end_frame();
    @(negedge i_Clk);
    i_CS_n = 1'b1;
    @(negedge i_Clk);
  endtask

  // One byte; if exp_tx, the readback must appear exactly one cycle later.
  task automatic xfer(input string tag, input logic [7:0] b,
                      input bit exp_tx, input logic [7:0] exp_byte);
    @(negedge i_Clk);
    i_RX_DV   = 1'b1;
    i_RX_Byte = b;
    @(negedge i_Clk);
    i_RX_DV   = 1'b0;
    if (exp_tx) begin
      check({tag, "_dv"}, 32'(o_TX_DV), 32'd1);
      check({tag, "_byte"}, 32'(o_TX_Byte), 32'(exp_byte));
    end
    @(negedge i_Clk);
    check({tag, "_dv_low"}, 32'(o_TX_DV), 32'd0);
  endtask

  initial begin
    checks = 0; errors = 0; upd_cnt = 0; tx_cnt = 0;
    i_Rst = 1'b1; i_CS_n = 1'b1; i_RX_DV = 1'b0; i_RX_Byte = 8'h00;
    idle(3);
    i_Rst = 1'b0;
    idle(1);
    check("rst_enable",   32'(o_Enable),   32'h0);
    check("rst_prescale", 32'(o_Prescale), 32'h0);
    check("rst_duty",     o_Duty,          32'h0);
    check("rst_update",   32'(o_Update),   32'h0);
    check("rst_txdv",     32'(o_TX_DV),    32'h0);

    // Full write burst; outputs hold until frame end.
    upd_base = upd_cnt; tx_base = tx_cnt;
    start_frame();
    xfer("w1_cmd", 8'h80, 1'b0, 8'h00);
    xfer("w1_d0",  8'h0F, 1'b0, 8'h00);
    xfer("w1_d1",  8'h03, 1'b0, 8'h00);
    xfer("w1_d2",  8'h10, 1'b0, 8'h00);
    xfer("w1_d3",  8'h20, 1'b0, 8'h00);
    xfer("w1_d4",  8'h30, 1'b0, 8'h00);
    xfer("w1_d5",  8'h40, 1'b0, 8'h00);
    check("w1_shadow_only", o_Duty, 32'h0);
    end_frame();
    check("w1_update_pulse", 32'(o_Update),   32'd1);
    check("w1_enable",       32'(o_Enable),   32'hF);
    check("w1_prescale",     32'(o_Prescale), 32'h03);
    check("w1_duty",         o_Duty,          32'h40302010);
    idle(1);
    check("w1_update_low",   32'(o_Update),   32'd0);
    idle(2);
    check("w1_update_count", 32'(upd_cnt - upd_base), 32'd1);
    check("w1_no_tx",        32'(tx_cnt - tx_base),   32'd0);

    // Read burst of the duty registers.
    upd_base = upd_cnt; tx_base = tx_cnt;
    start_frame();
    xfer("r1_cmd", 8'h02, 1'b1, 8'h10);
    xfer("r1_x1",  8'h00, 1'b1, 8'h20);
    xfer("r1_x2",  8'h00, 1'b1, 8'h30);
    xfer("r1_x3",  8'h00, 1'b1, 8'h40);
    end_frame();
    idle(2);
    check("r1_no_update", 32'(upd_cnt - upd_base), 32'd0);
    check("r1_tx_count",  32'(tx_cnt - tx_base),   32'd4);

    // Write at ID wraps to CTRL.
    upd_base = upd_cnt;
    start_frame();
    xfer("w2_cmd", 8'hFF, 1'b0, 8'h00);
    xfer("w2_id",  8'h55, 1'b0, 8'h00);
    xfer("w2_ctl", 8'h07, 1'b0, 8'h00);
    end_frame();
    check("w2_update",   32'(o_Update),   32'd1);
    check("w2_enable",   32'(o_Enable),   32'h7);
    check("w2_prescale", 32'(o_Prescale), 32'h03);
    check("w2_duty",     o_Duty,          32'h40302010);
    idle(2);
    check("w2_update_count", 32'(upd_cnt - upd_base), 32'd1);

    // Read ID then wrap to CTRL; boundary of duty map; unmapped reads.
    upd_base = upd_cnt;
    start_frame();
    xfer("r2_id",   8'h7F, 1'b1, 8'hA5);
    xfer("r2_wrap", 8'h00, 1'b1, 8'h07);
    end_frame();
    start_frame();
    xfer("r3_duty3", 8'h05, 1'b1, 8'h40);
    xfer("r3_past",  8'h00, 1'b1, 8'h00);
    end_frame();
    start_frame();
    xfer("r4_unmap", 8'h10, 1'b1, 8'h00);
    end_frame();
    idle(2);
    check("rd_frames_no_update", 32'(upd_cnt - upd_base), 32'd0);

    // Command-only write and empty frame must not commit.
    upd_base = upd_cnt;
    start_frame();
    xfer("c1_cmd", 8'h81, 1'b0, 8'h00);
    end_frame();
    start_frame();
    end_frame();
    idle(2);
    check("cmd_only_no_update", 32'(upd_cnt - upd_base), 32'd0);
    check("cmd_only_prescale",  32'(o_Prescale), 32'h03);

    // Reset mid-frame discards everything.
    upd_base = upd_cnt;
    start_frame();
    xfer("rs_cmd", 8'h82, 1'b0, 8'h00);
    xfer("rs_d",   8'h99, 1'b0, 8'h00);
    @(negedge i_Clk);
    i_Rst = 1'b1;
    @(negedge i_Clk);
    i_Rst = 1'b0;
    idle(2);
    end_frame();
    idle(2);
    check("rs_no_update", 32'(upd_cnt - upd_base), 32'd0);
    check("rs_enable",    32'(o_Enable),   32'h0);
    check("rs_prescale",  32'(o_Prescale), 32'h0);
    check("rs_duty",      o_Duty,          32'h0);

    // Byte coincident with CS rise is dropped; earlier write commits.
    upd_base = upd_cnt;
    start_frame();
    xfer("co_cmd", 8'h83, 1'b0, 8'h00);
    xfer("co_d",   8'h11, 1'b0, 8'h00);
    @(negedge i_Clk);
    i_RX_DV   = 1'b1;
    i_RX_Byte = 8'h22;
    i_CS_n    = 1'b1;
    @(negedge i_Clk);
    i_RX_DV   = 1'b0;
    check("co_update", 32'(o_Update), 32'd1);
    check("co_duty",   o_Duty,        32'h00001100);
    idle(3);
    check("co_update_count", 32'(upd_cnt - upd_base), 32'd1);

    // CTRL bits above NUM_CH dropped; next frame starts while o_Update is high.
    upd_base = upd_cnt;
    start_frame();
    xfer("bb_cmd", 8'h80, 1'b0, 8'h00);
    xfer("bb_ctl", 8'hF3, 1'b0, 8'h00);
    end_frame();
    check("bb_update", 32'(o_Update), 32'd1);
    check("bb_enable", 32'(o_Enable), 32'h3);
    i_CS_n = 1'b0;
    idle(2);
    xfer("bb2_cmd", 8'h81, 1'b0, 8'h00);
    xfer("bb2_pre", 8'h44, 1'b0, 8'h00);
    end_frame();
    check("bb2_update",   32'(o_Update),   32'd1);
    check("bb2_prescale", 32'(o_Prescale), 32'h44);
    check("bb2_enable",   32'(o_Enable),   32'h3);
    idle(2);
    check("bb_update_count", 32'(upd_cnt - upd_base), 32'd2);
    start_frame();
    xfer("bb_rd_ctrl", 8'h00, 1'b1, 8'h03);
    end_frame();

    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_spi_cmd_decoder
